// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - calc_sequencer shared types, constants and helpers
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        EXEC  = 3'd2,
        CONV  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Unlisted codes fall back to PASS so a stray key never hangs the sequencer
    function automatic op_e decode_op(input logic [2:0] code);
        case (code)
            3'd1:    return OP_ADD;
            3'd2:    return OP_SUB;
            3'd3:    return OP_MUL;
            3'd4:    return OP_DIV;
            default: return OP_PASS;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every digit of 5 or more before the shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_sync_edge.sv
// rtl/calc_sync_edge.sv - synchroniser chain plus one-clock rising-edge pulse
module calc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_r;
    logic              last_r;

    // Synchronise the level, then register a pulse on its first high clock
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_r <= '0;
            last_r <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_r[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            last_r <= sync_r[STAGES-1];
            pulse  <= sync_r[STAGES-1] & ~last_r;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator op sequencer; CALC_BCD_EN adds BCD conversion of result
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH       = CALC_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               finish,
    input  logic [WIDTH-1:0]   src,
    input  logic [WIDTH-1:0]   dst,
    input  logic [7:0]         alu_op,
    input  logic               ack,
    output logic [2*WIDTH-1:0] result,
    output logic               neg,
    output logic               err,
    output logic               valid,
    output logic               busy
`ifdef CALC_BCD_EN
    ,
    output logic [BCD_W-1:0]   result_bcd
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef CALC_BCD_EN
    localparam int     CONV_W     = $clog2(2 * WIDTH);
    localparam state_e POST_WRITE = CONV;
`else
    localparam state_e POST_WRITE = DONE;
`endif

    state_e             state, state_next;
    logic               fin_pulse;
    logic [WIDTH-1:0]   a_r, b_r;
    op_e                op_r;
    logic [WIDTH-1:0]   hi_r, q_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff, add_sum;
    logic               div_ge, a_lt_b, b_zero;
    logic [WIDTH-1:0]   hi_next, lo_next, sub_mag;
    logic [2*WIDTH-1:0] latch_result;
    logic               unused_op_bits;

`ifdef CALC_BCD_EN
    logic [2*WIDTH-1:0] bin_r;
    logic [CONV_W-1:0]  conv_cnt;
    logic [BCD_W-1:0]   bcd_adj;
    assign bcd_adj = bcd_adjust(result_bcd);
`endif

    assign unused_op_bits = ^alu_op[7:3];

    calc_sync_edge #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .CLK      (CLK),
        .RESET    (RESET),
        .async_in (finish),
        .pulse    (fin_pulse)
    );

    // Per-step arithmetic: one shift-add / restoring-divide step and the single-cycle ops
    always_comb begin
        mul_sum   = {1'b0, hi_r} + (q_r[0] ? {1'b0, a_r} : '0);
        div_shift = {hi_r, q_r[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_r};
        div_ge    = div_shift >= {1'b0, b_r};
        if (op_r == OP_MUL) begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], q_r[WIDTH-1:1]};
        end else begin
            hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_next = {q_r[WIDTH-2:0], div_ge};
        end
        add_sum = {1'b0, a_r} + {1'b0, b_r};
        a_lt_b  = a_r < b_r;
        sub_mag = a_lt_b ? (b_r - a_r) : (a_r - b_r);
        b_zero  = (b_r == '0);
        case (op_r)
            OP_ADD:  latch_result = {{(WIDTH-1){1'b0}}, add_sum};
            OP_SUB:  latch_result = {{WIDTH{1'b0}}, sub_mag};
            OP_MUL:  latch_result = '0;
            OP_DIV:  latch_result = '0;
            default: latch_result = {{WIDTH{1'b0}}, a_r};
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; requests outside IDLE are dropped
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fin_pulse) state_next = LATCH;
            LATCH: begin
                case (op_r)
                    OP_MUL:  state_next = EXEC;
                    OP_DIV:  state_next = b_zero ? DONE : EXEC;
                    default: state_next = POST_WRITE;
                endcase
            end
            EXEC:  if (cnt_r == '0) state_next = POST_WRITE;
`ifdef CALC_BCD_EN
            CONV:  if (conv_cnt == '0) state_next = DONE;
`else
            CONV:  state_next = DONE;
`endif
            DONE:  if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    // Operand capture, iterative datapath and result registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= OP_PASS;
            hi_r       <= '0;
            q_r        <= '0;
            cnt_r      <= '0;
            result     <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
`ifdef CALC_BCD_EN
            bin_r      <= '0;
            conv_cnt   <= '0;
            result_bcd <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fin_pulse) begin
                        a_r    <= src;
                        b_r    <= dst;
                        op_r   <= decode_op(alu_op[2:0]);
                        result <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
`ifdef CALC_BCD_EN
                        result_bcd <= '0;
`endif
                    end
                end
                LATCH: begin
                    if (op_r == OP_MUL || (op_r == OP_DIV && !b_zero)) begin
                        hi_r  <= '0;
                        q_r   <= (op_r == OP_MUL) ? b_r : a_r;
                        cnt_r <= CNT_W'(WIDTH - 1);
                    end else begin
                        result <= latch_result;
                        neg    <= (op_r == OP_SUB) && a_lt_b;
                        err    <= (op_r == OP_DIV);
`ifdef CALC_BCD_EN
                        bin_r    <= latch_result;
                        conv_cnt <= CONV_W'(2 * WIDTH - 1);
`endif
                    end
                end
                EXEC: begin
                    hi_r  <= hi_next;
                    q_r   <= lo_next;
                    cnt_r <= cnt_r - 1'b1;
                    if (cnt_r == '0) begin
                        result <= {hi_next, lo_next};
`ifdef CALC_BCD_EN
                        bin_r    <= {hi_next, lo_next};
                        conv_cnt <= CONV_W'(2 * WIDTH - 1);
`endif
                    end
                end
`ifdef CALC_BCD_EN
                CONV: begin
                    result_bcd <= {bcd_adj[BCD_W-2:0], bin_r[2*WIDTH-1]};
                    bin_r      <= {bin_r[2*WIDTH-2:0], 1'b0};
                    conv_cnt   <= conv_cnt - 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed table-driven bench for calc_sequencer
module tb_calc_sequencer;

    localparam int WIDTH = 16;
`ifdef CALC_BCD_EN
    localparam int CONV_LAT = 2 * WIDTH;
`else
    localparam int CONV_LAT = 0;
`endif

    logic        CLK    = 1'b0;
    logic        RESET  = 1'b0;
    logic        finish = 1'b0;
    logic        ack    = 1'b0;
    logic [15:0] src    = '0;
    logic [15:0] dst    = '0;
    logic [7:0]  alu_op = '0;
    logic [31:0] result;
    logic        neg, err, valid, busy;
`ifdef CALC_BCD_EN
    logic [39:0] result_bcd;
`endif

    calc_sequencer #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .finish (finish),
        .src    (src),
        .dst    (dst),
        .alu_op (alu_op),
        .ack    (ack),
        .result (result),
        .neg    (neg),
        .err    (err),
        .valid  (valid),
        .busy   (busy)
`ifdef CALC_BCD_EN
        ,
        .result_bcd (result_bcd)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  op;
        logic [31:0] exp_res;
        logic        exp_neg;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Raise finish, then count clocks until valid (bounded)
    task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [7:0] o,
                          input bit toggle, output int lat);
        @(negedge CLK);
        src = s; dst = d; alu_op = o; finish = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 6) finish = 1'b0;
            if (toggle && lat == 10) finish = 1'b1;
            if (toggle && lat == 13) finish = 1'b0;
        end while (!valid && lat < 200);
    endtask

    task automatic ack_done(input string name);
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
        finish = 1'b0;
        chk({name, "_valid_fall"}, valid, 1'b0);
        chk({name, "_busy_fall"}, busy, 1'b0);
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int          lat;
        int          exp_lat;
        logic [31:0] held;
        bit          busy_seen;

        vecs[0]  = '{"add",      16'd123,   16'd456, 8'd1,  32'd579,        1'b0, 1'b0, 5};
        vecs[1]  = '{"sub_neg",  16'd5,     16'd9,   8'd2,  32'd4,          1'b1, 1'b0, 5};
        vecs[2]  = '{"sub_pos",  16'd9,     16'd5,   8'd2,  32'd4,          1'b0, 1'b0, 5};
        vecs[3]  = '{"mul",      16'd999,   16'd999, 8'd3,  32'h000F3A71,   1'b0, 1'b0, 21};
        vecs[4]  = '{"div",      16'd100,   16'd7,   8'd4,  32'h0002000E,   1'b0, 1'b0, 21};
        vecs[5]  = '{"div_zero", 16'd100,   16'd0,   8'd4,  32'd0,          1'b0, 1'b1, 5};
        vecs[6]  = '{"pass0",    16'hABCD,  16'd3,   8'd0,  32'h0000ABCD,   1'b0, 1'b0, 5};
        vecs[7]  = '{"pass7",    16'h1234,  16'd5,   8'd7,  32'h00001234,   1'b0, 1'b0, 5};
        vecs[8]  = '{"add_hi",   16'hFFFF,  16'hFFFF, 8'h09, 32'h0001FFFE,  1'b0, 1'b0, 5};
        vecs[9]  = '{"mul_max",  16'hFFFF,  16'hFFFF, 8'd3, 32'hFFFE0001,   1'b0, 1'b0, 21};
        vecs[10] = '{"div_one",  16'hFFFF,  16'd1,   8'd4,  32'h0000FFFF,   1'b0, 1'b0, 21};
        vecs[11] = '{"sub_eq",   16'd7,     16'd7,   8'd2,  32'd0,          1'b0, 1'b0, 5};

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_result", result, 32'd0);
        chk("rst_neg",    neg,    1'b0);
        chk("rst_err",    err,    1'b0);
        chk("rst_valid",  valid,  1'b0);
        chk("rst_busy",   busy,   1'b0);
`ifdef CALC_BCD_EN
        chk("rst_bcd",    result_bcd, 40'd0);
`endif
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        foreach (vecs[i]) begin
            run_op(vecs[i].src, vecs[i].dst, vecs[i].op, (i == 3), lat);
            exp_lat = vecs[i].lat + (vecs[i].exp_err ? 0 : CONV_LAT);
            chk({vecs[i].name, "_latency"}, lat, exp_lat);
            chk({vecs[i].name, "_result"}, result, vecs[i].exp_res);
            chk({vecs[i].name, "_neg"}, neg, vecs[i].exp_neg);
            chk({vecs[i].name, "_err"}, err, vecs[i].exp_err);
            chk({vecs[i].name, "_busy"}, busy, 1'b1);
`ifdef CALC_BCD_EN
            chk({vecs[i].name, "_bcd"}, result_bcd,
                vecs[i].exp_err ? 40'd0 : to_bcd(vecs[i].exp_res));
`endif
            if (i == 0) begin
                held = result;
                repeat (5) begin
                    @(negedge CLK);
                    chk("add_hold_valid", valid, 1'b1);
                end
                chk("add_hold_result", result, held);
            end
            ack_done(vecs[i].name);
            chk({vecs[i].name, "_result_after_ack"}, result, vecs[i].exp_res);
            if (i == 3) begin
                busy_seen = 1'b0;
                repeat (30) begin
                    @(negedge CLK);
                    if (busy || valid) busy_seen = 1'b1;
                end
                chk("mul_toggle_single_result", busy_seen, 1'b0);
            end
        end

        // Reset in the middle of a multiply
        @(negedge CLK);
        src = 16'd999; dst = 16'd999; alu_op = 8'd3; finish = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge CLK);
            if (c == 6) finish = 1'b0;
        end
        chk("midrst_busy_before", busy, 1'b1);
        RESET = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_neg",    neg,    1'b0);
        chk("midrst_err",    err,    1'b0);
        chk("midrst_valid",  valid,  1'b0);
        chk("midrst_busy",   busy,   1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        run_op(16'd1, 16'd1, 8'd1, 1'b0, lat);
        chk("post_rst_latency", lat, 5 + CONV_LAT);
        chk("post_rst_result", result, 32'd2);
        ack_done("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
